// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// FSM state encoding and error codes.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    WORD,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/loader_timeout.sv
// Saturating idle counter for the boot loader.
// expired fires on the cycle the count would reach LIMIT.
module loader_timeout #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expired = en && (r_cnt >= LIM_M1);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a checksummed program image from a byte stream into IMEM
// and holds the core in reset until the image is verified.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH     = 256,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code
);

  state_e r_state;
  state_e w_next;

  logic [15:0]     r_len;
  logic [7:0]      r_csum;
  logic [1:0]      r_byte_idx;
  logic [ADDR_W:0] r_word_idx;
  logic [23:0]     r_asm;

  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic        w_fire;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_word_end;
  logic        w_last;
  logic        w_tmo_en;
  logic        w_expired;
  logic        w_csum_ok;
  logic        w_we_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_core_rst_nxt;
  logic [1:0]  w_code_nxt;

  assign w_fire     = in_valid && r_in_ready;
  assign w_len      = {in_data, r_len[7:0]};
  assign w_len_bad  = (w_len == 16'd0) ||
                      ({1'b0, w_len} > 17'(IMEM_DEPTH));
  assign w_word_end = (r_state == WORD) && w_fire &&
                      (r_byte_idx == 2'd3);
  assign w_last     = (16'(r_word_idx) == (r_len - 16'd1));
  assign w_csum_ok  = (in_data == r_csum);
  assign w_tmo_en   = (r_state == LEN_HI) ||
                      (r_state == WORD) ||
                      (r_state == CHECK);

  loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_fire),
    .en      (w_tmo_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LEN_LO;
    end else begin
      r_state <= w_next;
    end
  end

  // A consumed byte always takes priority over an expiring timer.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LEN_LO: begin
        if (w_fire) w_next = LEN_HI;
      end
      LEN_HI: begin
        if (w_fire) w_next = w_len_bad ? ERROR : WORD;
        else if (w_expired) w_next = ERROR;
      end
      WORD: begin
        if (w_fire) begin
          if (w_word_end && w_last) w_next = CHECK;
        end else if (w_expired) begin
          w_next = ERROR;
        end
      end
      CHECK: begin
        if (w_fire) w_next = w_csum_ok ? DONE : ERROR;
        else if (w_expired) w_next = ERROR;
      end
      DONE:    w_next = DONE;
      ERROR:   w_next = ERROR;
      default: w_next = LEN_LO;
    endcase
  end

  always_comb begin
    w_we_nxt       = w_word_end;
    w_done_nxt     = (w_next == DONE);
    w_err_nxt      = (w_next == ERROR);
    w_core_rst_nxt = (w_next != DONE);
    w_code_nxt     = r_err_code;
    if ((w_next == ERROR) && (r_state != ERROR)) begin
      unique case (1'b1)
        (r_state == LEN_HI) && w_fire: w_code_nxt = ERR_LEN;
        (r_state == CHECK) && w_fire:  w_code_nxt = ERR_CSUM;
        default:                       w_code_nxt = ERR_TIMEOUT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= '0;
      r_csum     <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_asm      <= '0;
    end else if (w_fire) begin
      unique case (r_state)
        LEN_LO: begin
          r_len[7:0] <= in_data;
          r_csum     <= r_csum ^ in_data;
        end
        LEN_HI: begin
          r_len[15:8] <= in_data;
          r_csum      <= r_csum ^ in_data;
          r_byte_idx  <= '0;
          r_word_idx  <= '0;
        end
        WORD: begin
          r_csum     <= r_csum ^ in_data;
          r_byte_idx <= r_byte_idx + 2'd1;
          unique case (r_byte_idx)
            2'd0: r_asm[7:0]   <= in_data;
            2'd1: r_asm[15:8]  <= in_data;
            2'd2: r_asm[23:16] <= in_data;
            default: r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_in_ready <= 1'b1;
      r_we       <= w_we_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_code_nxt;
      if (w_word_end) begin
        r_addr  <= r_word_idx[ADDR_W-1:0];
        r_wdata <= {in_data, r_asm};
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_reset = r_core_rst;
  assign load_done  = r_done;
  assign load_error = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Runs with a 10-cycle idle timeout.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  int total = 0;
  int bad = 0;

  logic [7:0]  wq_a[$];
  logic [31:0] wq_d[$];

  imem_boot_loader #(
    .IMEM_DEPTH     (256),
    .ADDR_W         (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (imem_we === 1'b1) begin
      wq_a.push_back(imem_addr);
      wq_d.push_back(imem_wdata);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic stop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rst();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", in_ready);
    end
    total++;
    if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_imem got we=%b a=%h d=%h want 0", imem_we, imem_addr, imem_wdata);
    end
    total++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_core got cr=%b dn=%b want cr=1 dn=0", core_reset, load_done);
    end
    total++;
    if (load_error !== 1'b0 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL rst_err got le=%b ec=%0d want 0", load_error, err_code);
    end
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    logic [7:0] f [11];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    rst();
    for (int i = 0; i < 11; i++) send(f[i]);
    total++;
    if (load_done !== 1'b0 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL good_early got dn=%b cr=%b want dn=0 cr=1", load_done, core_reset);
    end
    stop();
    total++;
    if (load_done !== 1'b1 || core_reset !== 1'b0) begin
      bad++;
      $display("FAIL good_done got dn=%b cr=%b want dn=1 cr=0", load_done, core_reset);
    end
    total++;
    if (wq_a.size() != 2) begin
      bad++; $display("FAIL good_nwr got=%0d want=2", wq_a.size());
    end
    if (wq_a.size() >= 2) begin
      total++;
      if (wq_a[0] !== 8'd0 || wq_d[0] !== 32'h00000013) begin
        bad++; $display("FAIL good_w0 got a=%h d=%h want a=00 d=00000013", wq_a[0], wq_d[0]);
      end
      total++;
      if (wq_a[1] !== 8'd1 || wq_d[1] !== 32'h00100093) begin
        bad++; $display("FAIL good_w1 got a=%h d=%h want a=01 d=00100093", wq_a[1], wq_d[1]);
      end
    end
    send(8'h55);
    stop();
    total++;
    if (load_done !== 1'b1 || in_ready !== 1'b1 || load_error !== 1'b0 || wq_a.size() != 2) begin
      bad++;
      $display("FAIL done_hold got dn=%b rdy=%b le=%b nwr=%0d want 1 1 0 2",
               load_done, in_ready, load_error, wq_a.size());
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] f [11];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    rst();
    for (int i = 0; i < 11; i++) send(f[i]);
    stop();
    total++;
    if (load_error !== 1'b1 || err_code !== 2'd2) begin
      bad++; $display("FAIL csum_err got le=%b ec=%0d want le=1 ec=2", load_error, err_code);
    end
    total++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      bad++; $display("FAIL csum_core got cr=%b dn=%b want cr=1 dn=0", core_reset, load_done);
    end
    total++;
    if (wq_a.size() != 2) begin
      bad++; $display("FAIL csum_nwr got=%0d want=2", wq_a.size());
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] lo [2];
    logic [7:0] hi [2];
    lo = '{8'h00, 8'h01};
    hi = '{8'h00, 8'h01};
    for (int t = 0; t < 2; t++) begin
      rst();
      send(lo[t]);
      send(hi[t]);
      total++;
      if (load_error !== 1'b0) begin
        bad++; $display("FAIL len_early case=%0d got le=%b want 0", t, load_error);
      end
      stop();
      total++;
      if (load_error !== 1'b1 || err_code !== 2'd1) begin
        bad++; $display("FAIL len_err case=%0d got le=%b ec=%0d want le=1 ec=1", t, load_error, err_code);
      end
      repeat (2) @(negedge clk);
      total++;
      if (wq_a.size() != 0 || core_reset !== 1'b1) begin
        bad++; $display("FAIL len_nowr case=%0d got nwr=%0d cr=%b want 0 1", t, wq_a.size(), core_reset);
      end
    end
  endtask

  task automatic test_timeout();
    int early;
    rst();
    send(8'h02);
    send(8'h00);
    send(8'h13);
    stop();
    early = 0;
    for (int i = 0; i < 10; i++) begin
      if (load_error !== 1'b0) early++;
      @(negedge clk);
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL tmo_early got=%0d early errors want=0", early);
    end
    total++;
    if (load_error !== 1'b1 || err_code !== 2'd3 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL tmo_err got le=%b ec=%0d cr=%b want le=1 ec=3 cr=1", load_error, err_code, core_reset);
    end
  endtask

  task automatic test_no_timeout();
    rst();
    send(8'h02);
    send(8'h00);
    send(8'h13);
    stop();
    repeat (8) @(negedge clk);
    in_data  = 8'h00;
    in_valid = 1'b1;
    stop();
    total++;
    if (load_error !== 1'b0) begin
      bad++; $display("FAIL tmo_9 got le=%b ec=%0d want le=0", load_error, err_code);
    end
    @(negedge clk);
    total++;
    if (load_error !== 1'b0) begin
      bad++; $display("FAIL tmo_9b got le=%b want 0", load_error);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f [7];
    f = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    rst();
    send(8'h02);
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    send(8'hEE);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (imem_we !== 1'b0 || core_reset !== 1'b1) begin
      bad++; $display("FAIL mid_rst got we=%b cr=%b want we=0 cr=1", imem_we, core_reset);
    end
    reset = 1'b0;
    wq_a.delete();
    wq_d.delete();
    for (int i = 0; i < 7; i++) send(f[i]);
    stop();
    total++;
    if (load_done !== 1'b1 || load_error !== 1'b0) begin
      bad++; $display("FAIL mid_done got dn=%b le=%b want dn=1 le=0", load_done, load_error);
    end
    total++;
    if (wq_a.size() != 1) begin
      bad++; $display("FAIL mid_nwr got=%0d want=1", wq_a.size());
    end else if (wq_a[0] !== 8'd0 || wq_d[0] !== 32'h12345678) begin
      bad++; $display("FAIL mid_w0 got a=%h d=%h want a=00 d=12345678", wq_a[0], wq_d[0]);
    end
  endtask

  task automatic test_full();
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] exp_w [256];
    int n;
    rst();
    cs = 8'h01;
    send(8'h00);
    send(8'h01);
    for (int w = 0; w < 256; w++) begin
      exp_w[w] = 32'h0;
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        exp_w[w][8*k +: 8] = b;
        cs ^= b;
        send(b);
      end
    end
    send(cs);
    stop();
    total++;
    if (load_done !== 1'b1 || core_reset !== 1'b0) begin
      bad++; $display("FAIL full_done got dn=%b cr=%b want dn=1 cr=0", load_done, core_reset);
    end
    total++;
    if (wq_a.size() != 256) begin
      bad++; $display("FAIL full_nwr got=%0d want=256", wq_a.size());
    end
    n = (wq_a.size() < 256) ? wq_a.size() : 256;
    for (int i = 0; i < n; i++) begin
      total++;
      if (wq_a[i] !== 8'(i) || wq_d[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL full_w%0d got a=%h d=%h want a=%h d=%h", i, wq_a[i], wq_d[i], 8'(i), exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_no_timeout();
    test_reset_midframe();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
